stream_buffer_ctrl: RTL and testbench

Demand-miss front end for the instruction-side `stream_buffer`. It accepts line-miss requests from the cache, serves them from the stream buffer when the buffered line matches, otherwise invalidates the buffer and launches a demand fetch. After each response it optionally prefetches the next sequential line. It sits between the I-cache refill port and `stream_buffer`, driving its `label_i`/`label_i_rdy`/`inv` inputs and consuming `label_o`/`data`.

---
 rtl/stream_buffer_ctrl.sv | 144 ++++++++++++++
 tb/tb_stream_buffer_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_buffer_ctrl.sv
// Demand-miss front end for the I-side stream buffer: serves cache line misses from the buffer or launches a demand fetch.
// Latency: a full hit responds the cycle after acceptance; a miss responds the cycle after the matching line turns valid.
// Backpressure: req_rdy only in IDLE; a response is held stable until resp_rdy; fetch strobes wait for sb_ready.
//
// Optional feature: STREAM_PREFETCH_EN adds the PREF state, which issues the next sequential line after every response.
//
// Ports:
//   clk, rst                          single clock, asynchronous active-high reset
//   req_vld/req_label/req_rdy         line-miss request from the I-cache
//   resp_vld/resp_data/resp_rdy       registered line response to the I-cache
//   sb_label_i/sb_label_i_rdy/sb_inv  fetch label, fetch strobe and invalidate strobe to the stream buffer
//   sb_ready                          stream buffer can take a fetch this cycle
//   sb_label_o/sb_label_o_vld         label held or in flight inside the stream buffer
//   sb_data/sb_data_vld               buffered line and its validity
//   hit_cnt/miss_cnt                  saturating hit/miss statistics
module stream_buffer_ctrl #(
    parameter int LINE_WIDTH  = 256,
    parameter int LABEL_WIDTH = 32 - $clog2(LINE_WIDTH / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_vld,
    input  logic [LABEL_WIDTH-1:0] req_label,
    output logic                   req_rdy,
    output logic                   resp_vld,
    output logic [LINE_WIDTH-1:0]  resp_data,
    input  logic                   resp_rdy,
    output logic [LABEL_WIDTH-1:0] sb_label_i,
    output logic                   sb_label_i_rdy,
    output logic                   sb_inv,
    input  logic                   sb_ready,
    input  logic [LABEL_WIDTH-1:0] sb_label_o,
    input  logic                   sb_label_o_vld,
    input  logic [LINE_WIDTH-1:0]  sb_data,
    input  logic                   sb_data_vld,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
`ifdef STREAM_PREFETCH_EN
        RESP  = 3'd3,
        PREF  = 3'd4
`else
        RESP  = 3'd3
`endif
    } state_t;

    state_t                 state;
    logic [LABEL_WIDTH-1:0] cur_label;
    logic                   req_match;
    logic                   cur_match;
    logic                   fetch_state;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A label match alone is a hit: the line is either present or already on its way.
    assign req_match = sb_label_o_vld && (sb_label_o == req_label);
    assign cur_match = sb_label_o_vld && sb_data_vld && (sb_label_o == cur_label);

`ifdef STREAM_PREFETCH_EN
    assign fetch_state = (state == ISSUE) || (state == PREF);
`else
    assign fetch_state = (state == ISSUE);
`endif

    // Strobes are combinational so they land in the same cycle as the decision.
    // sb_inv only fires in IDLE and the fetch strobe never does, so they cannot overlap.
    assign req_rdy        = (state == IDLE);
    assign sb_inv         = (state == IDLE) && req_vld && !req_match && sb_label_o_vld;
    assign sb_label_i_rdy = fetch_state && sb_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_label  <= '0;
            resp_vld   <= 1'b0;
            resp_data  <= '0;
            sb_label_i <= '0;
            hit_cnt    <= 32'd0;
            miss_cnt   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        cur_label <= req_label;
                        if (req_match) begin
                            hit_cnt <= sat_inc(hit_cnt);
                            if (sb_data_vld) begin
                                resp_data <= sb_data;
                                resp_vld  <= 1'b1;
                                state     <= RESP;
                            end else begin
                                state <= WAIT;
                            end
                        end else begin
                            miss_cnt   <= sat_inc(miss_cnt);
                            sb_label_i <= req_label;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (sb_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cur_match) begin
                        resp_data <= sb_data;
                        resp_vld  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        resp_vld <= 1'b0;
`ifdef STREAM_PREFETCH_EN
                        // Next sequential line; the label wraps naturally at its width.
                        sb_label_i <= cur_label + {{(LABEL_WIDTH-1){1'b0}}, 1'b1};
                        state      <= PREF;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef STREAM_PREFETCH_EN
                PREF: begin
                    if (sb_ready) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_buffer_ctrl.sv
// Bench for stream_buffer_ctrl: a behavioural stream buffer with random readiness and fetch latency,
// a memory where word i = i, table-driven and random request sequences, and a mid-WAIT reset.
// Expected data, hit/miss classification and strobe labels come from the buffer contents and line arithmetic.
module tb_stream_buffer_ctrl;

    localparam int LW = 256;
    localparam int AW = 27;

    logic          clk;
    logic          rst;
    logic          req_vld;
    logic [AW-1:0] req_label;
    logic          req_rdy;
    logic          resp_vld;
    logic [LW-1:0] resp_data;
    logic          resp_rdy;
    logic [AW-1:0] sb_label_i;
    logic          sb_label_i_rdy;
    logic          sb_inv;
    logic          sb_ready;
    logic [AW-1:0] sb_label_o;
    logic          sb_label_o_vld;
    logic [LW-1:0] sb_data;
    logic          sb_data_vld;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;

    stream_buffer_ctrl #(.LINE_WIDTH(LW), .LABEL_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_vld        (req_vld),
        .req_label      (req_label),
        .req_rdy        (req_rdy),
        .resp_vld       (resp_vld),
        .resp_data      (resp_data),
        .resp_rdy       (resp_rdy),
        .sb_label_i     (sb_label_i),
        .sb_label_i_rdy (sb_label_i_rdy),
        .sb_inv         (sb_inv),
        .sb_ready       (sb_ready),
        .sb_label_o     (sb_label_o),
        .sb_label_o_vld (sb_label_o_vld),
        .sb_data        (sb_data),
        .sb_data_vld    (sb_data_vld),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: line L holds words 8L..8L+7 (word k in bits 32k+31:32k).
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] l);
        logic [LW-1:0] v;
        logic [31:0]   base;
        base = {2'b00, l, 3'b000};
        v = '0;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    // Behavioural one-line stream buffer.
    int unsigned   lat_lo = 1;
    int unsigned   lat_hi = 5;
    int unsigned   lat_cnt;
    logic [AW-1:0] strobes[$];

    assign sb_data = line_of(sb_label_o);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_label_o     <= '0;
            sb_label_o_vld <= 1'b0;
            sb_data_vld    <= 1'b0;
            sb_ready       <= 1'b1;
            lat_cnt        <= 0;
        end else begin
            sb_ready <= ($urandom_range(0, 3) != 0);
            if (sb_label_i_rdy) begin
                sb_label_o     <= sb_label_i;
                sb_label_o_vld <= 1'b1;
                sb_data_vld    <= 1'b0;
                lat_cnt        <= $urandom_range(lat_hi, lat_lo);
                strobes.push_back(sb_label_i);
            end else if (sb_inv) begin
                sb_label_o_vld <= 1'b0;
                sb_data_vld    <= 1'b0;
            end else if (sb_label_o_vld && !sb_data_vld) begin
                if (lat_cnt <= 1) sb_data_vld <= 1'b1;
                else lat_cnt <= lat_cnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_hit = 0;
    int exp_miss = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle, checking the strobe rules on the way; returns at the next negedge.
    task automatic tick();
        #1;
        chk1("inv_strobe_exclusive", sb_inv && sb_label_i_rdy, 1'b0);
        if (sb_label_i_rdy) chk1("strobe_needs_ready", sb_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req_rdy"}, req_rdy, 1'b1);
        chk1({tag, "_resp_vld"}, resp_vld, 1'b0);
        chkw({tag, "_resp_data"}, resp_data, '0);
        chk32({tag, "_sb_label_i"}, 32'(sb_label_i), 32'd0);
        chk1({tag, "_sb_label_i_rdy"}, sb_label_i_rdy, 1'b0);
        chk1({tag, "_sb_inv"}, sb_inv, 1'b0);
        chk32({tag, "_hit_cnt"}, hit_cnt, 32'd0);
        chk32({tag, "_miss_cnt"}, miss_cnt, 32'd0);
    endtask

    // One full request/response transaction. t_hit/t_inv < 0: classify from the buffer contents.
    task automatic do_req(input logic [AW-1:0] lbl, input int hold, input int t_hit, input int t_inv);
        logic          hit_p;
        logic          inv_p;
        int            match_cyc;
        int            cyc;
        int            str_cyc;
        int            qbase;
        int            n;
        logic [AW-1:0] nxt;
        logic [AW-1:0] exp_str[$];

        chk1("req_rdy_before_req", req_rdy, 1'b1);
        hit_p = sb_label_o_vld && (sb_label_o == lbl);
        inv_p = !hit_p && sb_label_o_vld;
        if (t_hit >= 0) hit_p = (t_hit != 0);
        if (t_inv >= 0) inv_p = (t_inv != 0);
        match_cyc = (sb_label_o_vld && sb_data_vld && sb_label_o == lbl) ? 0 : -1;
        qbase = strobes.size();
        nxt = lbl + 1'b1;
        if (!hit_p) exp_str.push_back(lbl);
`ifdef STREAM_PREFETCH_EN
        exp_str.push_back(nxt);
`endif
        if (hit_p) exp_hit++;
        else exp_miss++;

        req_vld = 1'b1;
        req_label = lbl;
        #1;
        chk1("sb_inv_at_accept", sb_inv, inv_p);
        tick();
        req_vld = 1'b0;
        req_label = '0;

        cyc = 1;
        while (!resp_vld && cyc < 300) begin
            if (match_cyc < 0 && sb_data_vld && sb_label_o_vld && sb_label_o == lbl) match_cyc = cyc;
            tick();
            cyc++;
        end
        if (!resp_vld) begin
            chk1("resp_vld_timeout", resp_vld, 1'b1);
            return;
        end
        chk32("resp_latency", 32'(cyc), 32'(match_cyc + 1));
        chkw("resp_data", resp_data, line_of(lbl));
        chk32("hit_cnt", hit_cnt, 32'(exp_hit));
        chk32("miss_cnt", miss_cnt, 32'(exp_miss));

        resp_rdy = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk1("hold_resp_vld", resp_vld, 1'b1);
            chkw("hold_resp_data", resp_data, line_of(lbl));
            chk1("hold_req_rdy", req_rdy, 1'b0);
            chk1("hold_no_fetch", sb_label_i_rdy, 1'b0);
            chk1("hold_no_inv", sb_inv, 1'b0);
        end
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        chk1("resp_vld_drops", resp_vld, 1'b0);

        cyc = 0;
        str_cyc = -1;
        while (!req_rdy && cyc < 100) begin
            if (sb_label_i_rdy) str_cyc = cyc;
            tick();
            cyc++;
        end
`ifdef STREAM_PREFETCH_EN
        chk32("req_rdy_after_pref", 32'(cyc), 32'(str_cyc + 1));
`else
        chk32("req_rdy_after_resp", 32'(cyc), 32'd0);
`endif

        n = strobes.size() - qbase;
        chk32("strobe_count", 32'(n), 32'(exp_str.size()));
        for (int i = 0; i < n && i < exp_str.size(); i++)
            chk32("strobe_label", 32'(strobes[qbase + i]), 32'(exp_str[i]));
    endtask

    typedef struct {
        logic [AW-1:0] label;
        int            hold;
        int            hit;
        int            inv;
    } vec_t;

    vec_t          tbl[7];
    logic [AW-1:0] last;
    int            cyc;

    initial begin
`ifdef STREAM_PREFETCH_EN
        tbl[0] = '{27'h0,       0,  0, 0};
        tbl[1] = '{27'h1,       1,  1, 0};
        tbl[2] = '{27'h5,       0,  0, 1};
        tbl[3] = '{27'h5,       10, 0, 1};
        tbl[4] = '{27'h6,       2,  1, 0};
        tbl[5] = '{27'h7FFFFFF, 0,  0, 1};
        tbl[6] = '{27'h0,       1,  1, 0};
`else
        tbl[0] = '{27'h0,       0,  0, 0};
        tbl[1] = '{27'h1,       1,  0, 1};
        tbl[2] = '{27'h5,       0,  0, 1};
        tbl[3] = '{27'h5,       10, 1, 0};
        tbl[4] = '{27'h6,       2,  0, 1};
        tbl[5] = '{27'h7FFFFFF, 0,  0, 1};
        tbl[6] = '{27'h0,       1,  0, 1};
`endif
        rst = 1'b1;
        req_vld = 1'b0;
        req_label = '0;
        resp_rdy = 1'b0;
        @(negedge clk);
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk_reset_outputs("after_reset");

        foreach (tbl[i]) do_req(tbl[i].label, tbl[i].hold, tbl[i].hit, tbl[i].inv);

        // Reset while waiting for a slow line.
        lat_lo = 30;
        lat_hi = 30;
        req_vld = 1'b1;
        req_label = 27'h9;
        tick();
        req_vld = 1'b0;
        cyc = 0;
        while (!sb_label_i_rdy && cyc < 100) begin
            tick();
            cyc++;
        end
        chk1("wait_strobe_seen", sb_label_i_rdy, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_wait_reset");
        tick();
        rst = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        lat_lo = 1;
        lat_hi = 5;
        tick();
        do_req(27'h3, 2, 0, 0);

        // Random requests, clustered near the previous label so hits happen.
        last = 27'h3;
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0: last = last + 1'b1;
                1: last = last;
                2: last = AW'($urandom_range(0, 15));
                default: last = AW'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) tick();
            do_req(last, int'($urandom_range(0, 3)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
